// File: rtl/prefetch_arbiter_pkg.sv
// Shared types for the L2 / physical-memory prefetch arbiter.
//   lc3b_block      : one 16-byte cache line
//   lc3b_line_tag   : line address (addr[15:LINE_OFFSET_BITS]) at the default line size
//   pf_arb_state_t  : arbiter FSM states
package prefetch_arbiter_pkg;

   localparam int LINE_OFFSET_BITS = 4;

   typedef logic [127:0]                  lc3b_block;
   typedef logic [15-LINE_OFFSET_BITS:0]  lc3b_line_tag;

   typedef enum logic [2:0] {
      IDLE,
      D_READ,
      D_WRITE,
      PF_READ,
      HIT_RESP
   } pf_arb_state_t;

endpackage

// File: rtl/prefetch_arbiter_line_buf.sv
// One-entry prefetch line buffer: valid bit, line tag and line data.
// Ports:
//   clk, reset     : clock, asynchronous active-low reset (clears valid only)
//   fill           : load fill_tag/fill_data and set valid
//   inval          : clear valid
//   dmd_tag        : demand line tag, compared -> dmd_hit
//   hint_tag       : prefetch hint line tag, compared -> hint_hit
//   data           : stored line
module prefetch_line_buf
   import prefetch_arbiter_pkg::*;
#(
   parameter int TAG_W = 12
)(
   input  logic             clk,
   input  logic             reset,
   input  logic             fill,
   input  logic [TAG_W-1:0] fill_tag,
   input  logic [127:0]     fill_data,
   input  logic             inval,
   input  logic [TAG_W-1:0] dmd_tag,
   input  logic [TAG_W-1:0] hint_tag,
   output logic             dmd_hit,
   output logic             hint_hit,
   output logic [127:0]     data
);

   logic             valid_q;
   logic [TAG_W-1:0] tag_q;
   lc3b_block        data_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         valid_q <= 1'b0;
      end else if (fill) begin
         valid_q <= 1'b1;
      end else if (inval) begin
         valid_q <= 1'b0;
      end
   end

   // Tag and data are only meaningful while valid_q is set.
   always_ff @(posedge clk) begin
      if (fill) begin
         tag_q  <= fill_tag;
         data_q <= fill_data;
      end
   end

   assign dmd_hit  = valid_q && (tag_q == dmd_tag);
   assign hint_hit = valid_q && (tag_q == hint_tag);
   assign data     = data_q;

endmodule

// File: rtl/prefetch_arbiter.sv
// Shares the single physical-memory port between L2 demand traffic and
// I-side next-line prefetches. Demand always wins; a prefetch is issued only
// when the port is idle and lands in a 1-entry line buffer that can answer
// later L2 reads without a memory access.
// Ports:
//   clk, reset                         : clock, asynchronous active-low reset
//   l2_pmem_address/read/write/wdata   : L2 demand request (held until resp)
//   l2_pmem_rdata, l2_pmem_resp        : L2 completion (1-cycle pulse)
//   I_prefetch, I_prefetch_address     : 1-cycle next-line prefetch hint
//   pmem_address/read/write/wdata      : memory request
//   pmem_rdata, pmem_resp              : memory completion
//   pf_hit_count                       : saturating count of buffer hits
module prefetch_arbiter
   import prefetch_arbiter_pkg::*;
#(
   parameter bit PF_ENABLE   = 1'b1,
   parameter int OFFSET_BITS = LINE_OFFSET_BITS
)(
   input  logic         clk,
   input  logic         reset,
   input  logic [15:0]  l2_pmem_address,
   input  logic         l2_pmem_read,
   input  logic         l2_pmem_write,
   input  logic [127:0] l2_pmem_wdata,
   output logic [127:0] l2_pmem_rdata,
   output logic         l2_pmem_resp,
   input  logic         I_prefetch,
   input  logic [15:0]  I_prefetch_address,
   output logic [15:0]  pmem_address,
   output logic         pmem_read,
   output logic         pmem_write,
   output logic [127:0] pmem_wdata,
   input  logic [127:0] pmem_rdata,
   input  logic         pmem_resp,
   output logic [15:0]  pf_hit_count
);

   localparam int TAG_W = 16 - OFFSET_BITS;

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   pf_arb_state_t    state;
   logic             pend_valid;
   logic [TAG_W-1:0] pend_tag;
   logic [TAG_W-1:0] pf_tag;
   logic [TAG_W-1:0] l2_tag;
   logic [TAG_W-1:0] hint_tag;
   logic             buf_dmd_hit;
   logic             buf_hint_hit;
   logic             buf_fill;
   logic             buf_inval;
   logic [127:0]     buf_data;
   logic             hint_take;
   logic             pf_start;
   logic             unused_hint_offset;

   assign l2_tag   = l2_pmem_address[15:OFFSET_BITS];
   assign hint_tag = I_prefetch_address[15:OFFSET_BITS];

   // Prefetches are always line-aligned, so the hint's offset bits carry no information.
   assign unused_hint_offset = ^I_prefetch_address[OFFSET_BITS-1:0];

   assign buf_fill  = (state == PF_READ) && pmem_resp;
   assign buf_inval = (state == IDLE) && l2_pmem_write && buf_dmd_hit;

   // A hint for a line already buffered, or already on its way in, is redundant.
   assign hint_take = I_prefetch && !buf_hint_hit &&
                      !((state == PF_READ) && (pf_tag == hint_tag));

   assign pf_start  = PF_ENABLE && (state == IDLE) && !l2_pmem_write &&
                      !l2_pmem_read && pend_valid;

   prefetch_line_buf #(.TAG_W(TAG_W)) u_line_buf (
      .clk       (clk),
      .reset     (reset),
      .fill      (buf_fill),
      .fill_tag  (pf_tag),
      .fill_data (pmem_rdata),
      .inval     (buf_inval),
      .dmd_tag   (l2_tag),
      .hint_tag  (hint_tag),
      .dmd_hit   (buf_dmd_hit),
      .hint_hit  (buf_hint_hit),
      .data      (buf_data)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state        <= IDLE;
         pend_valid   <= 1'b0;
         pf_hit_count <= 16'd0;
      end else begin
         unique case (state)
            IDLE: begin
               if (l2_pmem_write) begin
                  state <= D_WRITE;
                  if (pend_tag == l2_tag) pend_valid <= 1'b0;
               end else if (l2_pmem_read) begin
                  state <= buf_dmd_hit ? HIT_RESP : D_READ;
               end else if (pf_start) begin
                  state      <= PF_READ;
                  pend_valid <= 1'b0;
               end
            end
            D_READ, D_WRITE, PF_READ: begin
               if (pmem_resp) state <= IDLE;
            end
            HIT_RESP: begin
               pf_hit_count <= sat_inc16(pf_hit_count);
               state        <= IDLE;
            end
            default: state <= IDLE;
         endcase
         // A hint arriving this cycle is newer than anything cleared above.
         if (hint_take) pend_valid <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (hint_take) pend_tag <= hint_tag;
      if (pf_start)  pf_tag   <= pend_tag;
   end

   // Demand read data and completion pass straight through from memory.
   always_comb begin
      pmem_address  = 16'd0;
      pmem_read     = 1'b0;
      pmem_write    = 1'b0;
      pmem_wdata    = 128'd0;
      l2_pmem_rdata = 128'd0;
      l2_pmem_resp  = 1'b0;
      unique case (state)
         D_READ: begin
            pmem_read    = 1'b1;
            pmem_address = l2_pmem_address;
            if (pmem_resp) begin
               l2_pmem_rdata = pmem_rdata;
               l2_pmem_resp  = 1'b1;
            end
         end
         D_WRITE: begin
            pmem_write   = 1'b1;
            pmem_address = l2_pmem_address;
            pmem_wdata   = l2_pmem_wdata;
            l2_pmem_resp = pmem_resp;
         end
         PF_READ: begin
            pmem_read    = 1'b1;
            pmem_address = {pf_tag, {OFFSET_BITS{1'b0}}};
         end
         HIT_RESP: begin
            l2_pmem_rdata = buf_data;
            l2_pmem_resp  = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_prefetch_arbiter.sv
module tb_prefetch_arbiter;

   localparam int MEM_LAT  = 5;
   localparam int OP_HINT  = 0;
   localparam int OP_READ  = 1;
   localparam int OP_WRITE = 2;
   localparam int NV       = 10;

   logic         clk;
   logic         reset;
   logic [15:0]  l2_pmem_address;
   logic         l2_pmem_read;
   logic         l2_pmem_write;
   logic [127:0] l2_pmem_wdata;
   logic [127:0] l2_pmem_rdata;
   logic         l2_pmem_resp;
   logic         I_prefetch;
   logic [15:0]  I_prefetch_address;
   logic [15:0]  pmem_address;
   logic         pmem_read;
   logic         pmem_write;
   logic [127:0] pmem_wdata;
   logic [127:0] pmem_rdata;
   logic         pmem_resp;
   logic [15:0]  pf_hit_count;

   // second instance with prefetching disabled; only hints reach it
   logic         z1;
   logic [15:0]  z16;
   logic [127:0] z128;
   logic [127:0] nopf_l2_pmem_rdata;
   logic         nopf_l2_pmem_resp;
   logic [15:0]  nopf_pmem_address;
   logic         nopf_pmem_read;
   logic         nopf_pmem_write;
   logic [127:0] nopf_pmem_wdata;
   logic [15:0]  nopf_pf_hit_count;

   prefetch_arbiter dut (
      .clk(clk), .reset(reset),
      .l2_pmem_address(l2_pmem_address), .l2_pmem_read(l2_pmem_read),
      .l2_pmem_write(l2_pmem_write), .l2_pmem_wdata(l2_pmem_wdata),
      .l2_pmem_rdata(l2_pmem_rdata), .l2_pmem_resp(l2_pmem_resp),
      .I_prefetch(I_prefetch), .I_prefetch_address(I_prefetch_address),
      .pmem_address(pmem_address), .pmem_read(pmem_read), .pmem_write(pmem_write),
      .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
      .pf_hit_count(pf_hit_count)
   );

   prefetch_arbiter #(.PF_ENABLE(1'b0)) dut_nopf (
      .clk(clk), .reset(reset),
      .l2_pmem_address(z16), .l2_pmem_read(z1),
      .l2_pmem_write(z1), .l2_pmem_wdata(z128),
      .l2_pmem_rdata(nopf_l2_pmem_rdata), .l2_pmem_resp(nopf_l2_pmem_resp),
      .I_prefetch(I_prefetch), .I_prefetch_address(I_prefetch_address),
      .pmem_address(nopf_pmem_address), .pmem_read(nopf_pmem_read),
      .pmem_write(nopf_pmem_write), .pmem_wdata(nopf_pmem_wdata),
      .pmem_rdata(z128), .pmem_resp(z1),
      .pf_hit_count(nopf_pf_hit_count)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // memory model: fixed latency, one completion pulse, logs each completed access
   logic [127:0] mem_data;
   int           mem_cnt;
   logic [15:0]  log_addr [$];
   logic         log_wr [$];
   logic [127:0] log_wdata [$];

   task automatic clear_log();
      log_addr.delete();
      log_wr.delete();
      log_wdata.delete();
   endtask

   initial begin
      pmem_resp  = 1'b0;
      pmem_rdata = 128'd0;
      mem_cnt    = 0;
      forever begin
         @(posedge clk);
         #1;
         if (pmem_resp) begin
            pmem_resp  = 1'b0;
            pmem_rdata = 128'd0;
            mem_cnt    = 0;
         end else if (pmem_read || pmem_write) begin
            mem_cnt++;
            if (mem_cnt >= MEM_LAT) begin
               pmem_resp  = 1'b1;
               pmem_rdata = pmem_read ? mem_data : 128'd0;
               log_addr.push_back(pmem_address);
               log_wr.push_back(pmem_write);
               log_wdata.push_back(pmem_wdata);
            end
         end else begin
            mem_cnt = 0;
         end
      end
   end

   // observers
   int l2_resp_pulses = 0;
   int nopf_reads     = 0;
   int nopf_other     = 0;
   always @(negedge clk) begin
      if (l2_pmem_resp) l2_resp_pulses++;
      if (nopf_pmem_read) nopf_reads++;
      if (nopf_pmem_write || nopf_l2_pmem_resp || (|nopf_pmem_address) ||
          (|nopf_pmem_wdata) || (|nopf_l2_pmem_rdata) || (|nopf_pf_hit_count))
         nopf_other++;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // L2 agent: called just after a rising edge; lat = falling edges until resp seen
   task automatic l2_read(input logic [15:0] a, output logic [127:0] d, output int lat, output logic ok);
      l2_pmem_address = a;
      l2_pmem_read    = 1'b1;
      lat = 0; ok = 1'b0; d = 128'd0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         lat++;
         if (l2_pmem_resp) begin
            d  = l2_pmem_rdata;
            ok = 1'b1;
            break;
         end
      end
      @(posedge clk);
      #1;
      l2_pmem_read = 1'b0;
   endtask

   task automatic l2_write(input logic [15:0] a, input logic [127:0] wd, output int lat, output logic ok);
      l2_pmem_address = a;
      l2_pmem_wdata   = wd;
      l2_pmem_write   = 1'b1;
      lat = 0; ok = 1'b0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         lat++;
         if (l2_pmem_resp) begin
            ok = 1'b1;
            break;
         end
      end
      @(posedge clk);
      #1;
      l2_pmem_write = 1'b0;
   endtask

   task automatic send_hint(input logic [15:0] a);
      I_prefetch_address = a;
      I_prefetch         = 1'b1;
      @(posedge clk);
      #1;
      I_prefetch = 1'b0;
   endtask

   typedef struct {
      int           op;
      logic [15:0]  addr;
      logic [127:0] mdata;     // memory read data, or L2 write data for OP_WRITE
      int           exp_lat;
      logic [127:0] exp_data;
      int           exp_acc;
      logic [15:0]  exp_addr;
      logic         exp_wr;
      logic [15:0]  exp_cnt;
   } vec_t;

   vec_t         vecs [NV];
   vec_t         v;
   logic [127:0] d, d2;
   int           lat, lat2, pulses0;
   logic         ok, ok2;

   initial begin
      z1 = 1'b0; z16 = 16'd0; z128 = 128'd0;
      reset = 1'b0;
      l2_pmem_address = 16'd0; l2_pmem_read = 1'b0; l2_pmem_write = 1'b0;
      l2_pmem_wdata = 128'd0; I_prefetch = 1'b0; I_prefetch_address = 16'd0;
      mem_data = 128'd0;

      //               op        addr     mdata              lat data               acc addr     wr    cnt
      vecs[0] = '{OP_HINT,  16'h1230, {16{8'hAA}},        0, 128'd0,             1, 16'h1230, 1'b0, 16'd0};
      vecs[1] = '{OP_READ,  16'h1238, 128'd0,             2, {16{8'hAA}},        0, 16'h0000, 1'b0, 16'd1};
      vecs[2] = '{OP_READ,  16'h1230, 128'd0,             2, {16{8'hAA}},        0, 16'h0000, 1'b0, 16'd2};
      vecs[3] = '{OP_READ,  16'h2000, {16{8'h55}},        6, {16{8'h55}},        1, 16'h2000, 1'b0, 16'd2};
      vecs[4] = '{OP_READ,  16'h2000, {16{8'h66}},        6, {16{8'h66}},        1, 16'h2000, 1'b0, 16'd2};
      vecs[5] = '{OP_HINT,  16'h123C, {16{8'h11}},        0, 128'd0,             0, 16'h0000, 1'b0, 16'd2};
      vecs[6] = '{OP_HINT,  16'h6004, {16{8'h77}},        0, 128'd0,             1, 16'h6000, 1'b0, 16'd2};
      vecs[7] = '{OP_WRITE, 16'h6008, {8{16'hCAFE}},      6, 128'd0,             1, 16'h6008, 1'b1, 16'd2};
      vecs[8] = '{OP_READ,  16'h6000, {16{8'h88}},        6, {16{8'h88}},        1, 16'h6000, 1'b0, 16'd2};
      vecs[9] = '{OP_READ,  16'h1234, {16{8'h99}},        6, {16{8'h99}},        1, 16'h1234, 1'b0, 16'd2};

      // reset state
      #2;
      chk("rst pmem_read", pmem_read, 1'b0);
      chk("rst pmem_write", pmem_write, 1'b0);
      chk("rst l2_resp", l2_pmem_resp, 1'b0);
      chk("rst hit_count", pf_hit_count, 16'd0);
      chk("rst pmem_address", pmem_address, 16'd0);
      chk("rst l2_rdata", l2_pmem_rdata, 128'd0);
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;

      // table: prefetch, hits, misses, dropped hint, write invalidate
      for (int i = 0; i < NV; i++) begin
         v = vecs[i];
         mem_data = v.mdata;
         clear_log();
         if (v.op == OP_HINT) begin
            send_hint(v.addr);
            repeat (10) @(posedge clk);
            #1;
         end else if (v.op == OP_READ) begin
            l2_read(v.addr, d, lat, ok);
            chk($sformatf("v%0d done", i), ok, 1'b1);
            chk($sformatf("v%0d latency", i), lat, v.exp_lat);
            chk($sformatf("v%0d rdata", i), d, v.exp_data);
         end else begin
            l2_write(v.addr, v.mdata, lat, ok);
            chk($sformatf("v%0d done", i), ok, 1'b1);
            chk($sformatf("v%0d latency", i), lat, v.exp_lat);
         end
         chk($sformatf("v%0d pmem accesses", i), log_addr.size(), v.exp_acc);
         if (v.exp_acc > 0 && log_addr.size() > 0) begin
            chk($sformatf("v%0d pmem addr", i), log_addr[0], v.exp_addr);
            chk($sformatf("v%0d pmem write", i), log_wr[0], v.exp_wr);
            if (v.exp_wr) chk($sformatf("v%0d pmem wdata", i), log_wdata[0], v.mdata);
         end
         chk($sformatf("v%0d hit_count", i), pf_hit_count, v.exp_cnt);
      end

      // demand priority: read miss 0x4000 and hint 0x5000 in the same cycle
      clear_log();
      mem_data = {8{16'h4444}};
      fork
         send_hint(16'h5000);
         l2_read(16'h4000, d, lat, ok);
      join
      repeat (12) @(posedge clk);
      #1;
      chk("prio done", ok, 1'b1);
      chk("prio latency", lat, 6);
      chk("prio rdata", d, {8{16'h4444}});
      chk("prio accesses", log_addr.size(), 2);
      if (log_addr.size() == 2) begin
         chk("prio first addr", log_addr[0], 16'h4000);
         chk("prio second addr", log_addr[1], 16'h5000);
      end

      // newer hint replaces an older one captured while memory is busy
      clear_log();
      mem_data = {8{16'hA0A0}};
      fork
         l2_read(16'hA000, d, lat, ok);
         begin
            send_hint(16'hB000);
            send_hint(16'hC000);
         end
      join
      repeat (12) @(posedge clk);
      #1;
      chk("ovr accesses", log_addr.size(), 2);
      if (log_addr.size() == 2) begin
         chk("ovr demand addr", log_addr[0], 16'hA000);
         chk("ovr prefetch addr", log_addr[1], 16'hC000);
      end

      // asynchronous reset in the middle of a prefetch
      clear_log();
      mem_data = {8{16'h7070}};
      send_hint(16'h7000);
      repeat (2) @(posedge clk);
      #1;
      chk("pre-reset pmem_read", pmem_read, 1'b1);
      reset = 1'b0;
      #1;
      chk("reset pmem_read", pmem_read, 1'b0);
      chk("reset pmem_address", pmem_address, 16'd0);
      chk("reset hit_count", pf_hit_count, 16'd0);
      @(posedge clk);
      #1;
      reset = 1'b1;
      clear_log();
      l2_read(16'h7000, d, lat, ok);
      chk("post-reset latency", lat, 6);
      chk("post-reset rdata", d, {8{16'h7070}});
      chk("post-reset accesses", log_addr.size(), 1);
      clear_log();
      mem_data = {8{16'h5151}};
      l2_read(16'h5000, d, lat, ok);
      chk("post-reset old line latency", lat, 6);
      chk("post-reset old line accesses", log_addr.size(), 1);

      // demand arrives two cycles into a prefetch of the same line
      clear_log();
      mem_data = {16{8'hBB}};
      send_hint(16'h5000);
      repeat (3) @(posedge clk);
      #1;
      pulses0 = l2_resp_pulses;
      l2_read(16'h5004, d, lat, ok);
      repeat (4) @(posedge clk);
      #1;
      chk("stall latency", lat, 5);
      chk("stall rdata", d, {16{8'hBB}});
      chk("stall l2 resp pulses", l2_resp_pulses - pulses0, 1);
      chk("stall accesses", log_addr.size(), 1);
      if (log_addr.size() == 1) chk("stall pmem addr", log_addr[0], 16'h5000);
      chk("stall hit_count", pf_hit_count, 16'd1);

      // counter saturation
      force dut.pf_hit_count = 16'hFFFE;
      #1;
      release dut.pf_hit_count;
      #1;
      chk("sat preload", pf_hit_count, 16'hFFFE);
      for (int k = 0; k < 3; k++) begin
         l2_read(16'h5008, d2, lat2, ok2);
         chk($sformatf("sat hit%0d latency", k), lat2, 2);
         chk($sformatf("sat hit%0d count", k), pf_hit_count, 16'hFFFF);
      end
      repeat (3) @(posedge clk);
      #1;
      chk("sat hold", pf_hit_count, 16'hFFFF);

      // hint stream: the prefetch-disabled instance must never touch memory
      for (int k = 0; k < 6; k++) begin
         send_hint(16'h8000 + 16'(k * 16'h0130));
         repeat (3) @(posedge clk);
         #1;
      end
      repeat (20) @(posedge clk);
      #1;
      chk("nopf pmem_read cycles", nopf_reads, 0);
      chk("nopf other activity", nopf_other, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
